// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding register.
// The frame format (data bits, parity, stop bits) is fixed when the design is built.
// o_Tx_Serial is registered, so the line trails the FSM state by one clock.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 100,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic                 r_frame_end;
  logic                 r_serial;
  logic                 r_active;
  logic                 r_done;

  logic w_bit_end;
  logic w_last_stop;
  logic w_load;
  logic w_par_bit;
  logic w_line;

  assign w_bit_end   = (r_clk_cnt == CNT_LAST);
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_idx == STOP_LAST);
  // Transfer only from IDLE or on the very last cycle of the final stop bit,
  // which gives back-to-back frames with no idle gap.
  assign w_load      = r_hold_full && ((r_state == S_IDLE) || w_last_stop);
  // Even parity bit equals the XOR of the data; odd parity is its complement.
  assign w_par_bit   = (PARITY == 1) ? ~(^r_hold) : (^r_hold);

  // Holding register: accept when empty, release to the shifter on transfer.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (i_Tx_DV && !r_hold_full) begin
      r_hold      <= i_Tx_Byte;
      r_hold_full <= 1'b1;
    end
  end

  // Frame sequencer: bit timing, data index and state transitions.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= 1'b0;
      if (r_state != S_IDLE) begin
        r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_shift   <= r_hold;
            r_parity  <= w_par_bit;
            r_state   <= S_START;
            r_clk_cnt <= '0;
            r_idx     <= '0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_idx   <= '0;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_idx == DATA_LAST) begin
              r_idx   <= '0;
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_idx   <= '0;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_idx == STOP_LAST) begin
              r_frame_end <= 1'b1;
              r_idx       <= '0;
              if (w_load) begin
                r_shift  <= r_hold;
                r_parity <= w_par_bit;
                r_state  <= S_START;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Line level implied by the current state, before the output register.
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_START:  w_line = 1'b0;
      S_DATA:   w_line = r_shift[r_idx];
      S_PARITY: w_line = r_parity;
      default:  w_line = 1'b1;
    endcase
  end

  // Registered outputs; Active and Done share the one-cycle lag of the line.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_serial <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_serial <= w_line;
      r_active <= (r_state != S_IDLE);
      r_done   <= r_frame_end;
    end
  end

  assign o_Tx_Ready  = ~r_hold_full;
  assign o_Tx_Active = r_active;
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1, 7E2, 7O2) at 4 clocks per bit.
// Bytes are queued when accepted and popped when a frame is decoded off the line.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dv;
  logic [7:0] din0;
  logic [6:0] din1;
  logic [6:0] din2;
  logic [2:0] ser, rdy, act, dn;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic [63:0] cap_ser, cap_act, cap_dn, cap_rdy;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(din0),
    .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(dn[0]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(din1),
    .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(dn[1]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(din2),
    .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(dn[2]));

  task automatic set_in(input int k, input logic v, input logic [7:0] b);
    dv[k] = v;
    case (k)
      0: din0 = b;
      1: din1 = b[6:0];
      default: din2 = b[6:0];
    endcase
  endtask

  // Handshake one byte; returns on the negedge right after the accepting edge.
  task automatic send(input int k, input logic [7:0] b);
    @(negedge clk);
    for (int i = 0; i < 200 && rdy[k] !== 1'b1; i++) @(negedge clk);
    set_in(k, 1'b1, b);
    @(negedge clk);
    set_in(k, 1'b0, b);
    q.push_back(b);
  endtask

  task automatic wait_start(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (ser[k] === 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Record n cycles of outputs; optionally offer a byte at cycle inj_at.
  task automatic capture(input int k, input int n, input int inj_at, input logic [7:0] inj_b);
    for (int i = 0; i < n; i++) begin
      cap_ser[i] = ser[k];
      cap_act[i] = act[k];
      cap_dn[i]  = dn[k];
      cap_rdy[i] = rdy[k];
      if (inj_at >= 0 && i == inj_at) set_in(k, 1'b1, inj_b);
      if (inj_at >= 0 && i == inj_at + 1) begin
        set_in(k, 1'b0, inj_b);
        q.push_back(inj_b);
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [7:0] decode(input int db);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < db; i++) r[i] = cap_ser[4 * (i + 1) + 2];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    dv = '0; din0 = '0; din1 = '0; din2 = '0;
    repeat (3) @(negedge clk);
    checks++; if (ser !== 3'b111) begin errors++; $display("FAIL reset_serial: got %b want 111", ser); end
    checks++; if (rdy !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", rdy); end
    checks++; if (act !== 3'b000) begin errors++; $display("FAIL reset_active: got %b want 000", act); end
    checks++; if (dn !== 3'b000)  begin errors++; $display("FAIL reset_done: got %b want 000", dn); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_send();
    logic [9:0] fr;
    logic [7:0] got, exp;
    int bad_line, bad_act;
    fr = {1'b1, 8'hA5, 1'b0};
    send(0, 8'hA5);
    @(negedge clk);
    checks++; if (ser[0] !== 1'b1) begin errors++; $display("FAIL latency_early: serial got %b want 1 one edge after accept", ser[0]); end
    @(negedge clk);
    checks++; if (ser[0] !== 1'b0) begin errors++; $display("FAIL latency_start: serial got %b want 0 two edges after accept", ser[0]); end
    capture(0, 40, -1, 8'h00);
    bad_line = 0; bad_act = 0;
    for (int i = 0; i < 40; i++) begin
      if (cap_ser[i] !== fr[i / 4]) bad_line++;
      if (cap_act[i] !== 1'b1) bad_act++;
    end
    checks++; if (bad_line != 0) begin errors++; $display("FAIL a5_line: %0d wrong cycles want 0", bad_line); end
    checks++; if (bad_act != 0) begin errors++; $display("FAIL a5_active: %0d low cycles want 0", bad_act); end
    checks++; if (cap_dn[39:0] !== 40'h0) begin errors++; $display("FAIL a5_done_early: got %h want 0", cap_dn[39:0]); end
    checks++; if ({dn[0], act[0], ser[0]} !== 3'b101) begin errors++; $display("FAIL a5_frame_end: done/act/ser got %b want 101", {dn[0], act[0], ser[0]}); end
    @(negedge clk);
    checks++; if (dn[0] !== 1'b0) begin errors++; $display("FAIL a5_done_width: got %b want 0", dn[0]); end
    got = decode(8);
    exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
    checks++; if (got !== exp) begin errors++; $display("FAIL a5_data: got %h want %h", got, exp); end
  endtask

  task automatic test_parity();
    bit ok;
    logic [7:0] got, exp;
    logic pexp;
    for (int k = 1; k <= 2; k++) begin
      send(k, 8'h55);
      wait_start(k, ok);
      checks++; if (!ok) begin errors++; $display("FAIL par%0d_start: got no start bit want start", k); end
      capture(k, 44, -1, 8'h00);
      exp  = (q.size() > 0) ? q.pop_front() : 8'hxx;
      exp  = exp & 8'h7F;
      pexp = ($countones(exp) % 2 == 1) ? 1'b1 : 1'b0;
      if (k == 2) pexp = ~pexp;
      got = decode(7);
      checks++; if (got !== exp) begin errors++; $display("FAIL par%0d_data: got %h want %h", k, got, exp); end
      checks++; if (cap_ser[34] !== pexp) begin errors++; $display("FAIL par%0d_bit: got %b want %b", k, cap_ser[34], pexp); end
      checks++; if (cap_ser[43:36] !== 8'hFF) begin errors++; $display("FAIL par%0d_stop: got %h want ff", k, cap_ser[43:36]); end
      checks++; if (cap_dn[43:0] !== 44'h0 || dn[k] !== 1'b1 || act[k] !== 1'b0) begin
        errors++; $display("FAIL par%0d_len: done at 44 got %b act %b want 1 0", k, dn[k], act[k]);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad_rdy;
    logic [7:0] got, exp;
    logic er;
    send(0, 8'h01);
    wait_start(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_start: got no start bit want start"); end
    capture(0, 40, 5, 8'h80);
    bad_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      er = (i <= 5 || i == 39) ? 1'b1 : 1'b0;
      if (cap_rdy[i] !== er) bad_rdy++;
    end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL b2b_ready: %0d wrong cycles want 0", bad_rdy); end
    checks++; if (cap_act[39:0] !== {40{1'b1}}) begin errors++; $display("FAIL b2b_active1: got %h want all ones", cap_act[39:0]); end
    checks++; if ({dn[0], act[0], ser[0]} !== 3'b110) begin errors++; $display("FAIL b2b_seam: done/act/ser got %b want 110", {dn[0], act[0], ser[0]}); end
    got = decode(8);
    exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_data1: got %h want %h", got, exp); end
    capture(0, 40, -1, 8'h00);
    got = decode(8);
    exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_data2: got %h want %h", got, exp); end
    checks++; if (cap_act[39:0] !== {40{1'b1}}) begin errors++; $display("FAIL b2b_active2: got %h want all ones", cap_act[39:0]); end
    checks++; if ({dn[0], act[0]} !== 2'b10) begin errors++; $display("FAIL b2b_end: done/act got %b want 10", {dn[0], act[0]}); end
    repeat (2) @(negedge clk);
  endtask

  // DV held high: accepts land on edges 0, 2, 42 and 82 of the driver loop.
  task automatic test_dv_held();
    bit ok;
    fork
      begin
        for (int t = 0; t <= 100; t++) begin
          set_in(0, 1'b1, 8'h30 + 8'(t * 7));
          if (t == 0 || t == 2 || t == 42 || t == 82) q.push_back(8'h30 + 8'(t * 7));
          @(negedge clk);
        end
        set_in(0, 1'b0, 8'h00);
      end
      begin
        logic [7:0] got, exp;
        bit rok;
        for (int f = 0; f < 4; f++) begin
          wait_start(0, rok);
          checks++;
          if (!rok) begin
            errors++; $display("FAIL held_start%0d: got no start bit want start", f);
            break;
          end
          repeat (2) @(negedge clk);
          got = '0;
          for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            got[i] = ser[0];
          end
          repeat (4) @(negedge clk);
          if (ser[0] !== 1'b1) begin errors++; $display("FAIL held_stop%0d: got %b want 1", f, ser[0]); end
          exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
          checks++; if (got !== exp) begin errors++; $display("FAIL held_data%0d: got %h want %h", f, got, exp); end
        end
      end
    join
    repeat (2) @(negedge clk);
    wait_start(0, ok);
    checks++; if (ok) begin errors++; $display("FAIL held_extra: got extra frame want none"); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL held_queue: got %0d left want 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    logic [7:0] got, exp;
    send(0, 8'h3C);
    wait_start(0, ok);
    repeat (10) @(negedge clk);
    set_in(0, 1'b1, 8'hC3);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL mid_queued: ready got %b want 0", rdy[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ser[0], rdy[0], act[0], dn[0]} !== 4'b1100) begin
      errors++; $display("FAIL mid_async: ser/rdy/act/done got %b want 1100", {ser[0], rdy[0], act[0], dn[0]});
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ser[0] !== 1'b1 || act[0] !== 1'b0 || dn[0] !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_quiet: %0d active cycles want 0", bad); end
    send(0, 8'h5A);
    wait_start(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_restart: got no start bit want start"); end
    capture(0, 40, -1, 8'h00);
    got = decode(8);
    exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
    checks++; if (got !== exp) begin errors++; $display("FAIL mid_data: got %h want %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_idle_send();
    test_parity();
    test_back_to_back();
    test_dv_held();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the MMIO softcore peripheral set.
- Frame format is set at elaboration: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits.
- A one-entry holding register with a valid/ready handshake lets the bus side queue the next character while the current frame shifts. Back-to-back frames have no idle gap.
- Sits between the MMIO register block and the board TX pin.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Tx_DV  in  1  byte valid; the byte is accepted on an edge where i_Tx_DV and o_Tx_Ready are both high.
- i_Tx_Byte  in  DATA_BITS  character to send; sampled only on an accepting edge.
- o_Tx_Ready  out  1  holding register empty; a character can be accepted.
- o_Tx_Active  out  1  high from the first start bit until the end of the last queued frame.
- o_Tx_Serial  out  1  serial line; registered output; idle level is 1.
- o_Tx_Done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Outputs: o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0.
  - Internal state: FSM=IDLE, bit counter and holding register cleared.
  - Reset mid-frame aborts the frame immediately; the line goes high with no stop bit and the queued character is discarded.
- Holding register:
  - Loads i_Tx_Byte on an accepting edge; o_Tx_Ready then drops on that edge.
  - Transfers to the shift register when the FSM is in IDLE, or on the final cycle of the last stop bit. o_Tx_Ready rises on that transfer edge.
  - While full, i_Tx_DV is ignored and the register contents stay stable.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> START (if the holding register is full) or IDLE.
- Bit timing:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The bit counter runs 0..CLKS_PER_BIT-1, is $clog2-sized, and wraps to 0 at each bit boundary.
  - The data index runs 0..DATA_BITS-1. The stop phase lasts STOP_BITS*CLKS_PER_BIT cycles.
- Latency:
  - From idle, o_Tx_Serial falls at the second rising edge after the accepting edge: one edge to transfer into the shift register, one edge for the registered output.
  - Frame length is CLKS_PER_BIT*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- Parity: computed from the shifted character. Odd parity makes the total count of ones (data + parity bit) odd; even parity makes it even.
- o_Tx_Done: high for exactly one cycle, the first cycle after the last stop bit.
  - If a character is queued, that same cycle is the first cycle of its start bit (o_Tx_Serial=0).
  - o_Tx_Active then stays high without a gap.
- o_Tx_Active:
  - Rises together with the first start bit.
  - Falls together with o_Tx_Done only when nothing is queued.
- Simultaneous accept and transfer on the same edge: not possible, because acceptance requires the holding register to be empty. An accept on the transfer edge itself is taken on the following edge.
- Illegal parameter values stop elaboration via a generate-time error.

Test Plan:
- CLKS_PER_BIT=4, 8N1; reset, send 0xA5 from idle.
  - Serial falls 2 edges after acceptance.
  - Line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - Done pulses 1 cycle; Active is high for exactly 40 cycles.
- CLKS_PER_BIT=4, 7E2; send 0x55 (four ones).
  - Parity bit = 0, followed by 8 cycles of stop level; frame is 44 cycles.
- Same configuration with PARITY=1 (odd); send 0x55 -> parity bit = 1.
- Queue 0x01 then 0x80 while the first frame is active.
  - Ready is low from the second accept until the transfer at the end of frame 1.
  - Start bit of frame 2 coincides with Done; Active never drops between frames.
- i_Tx_DV held high continuously with changing data while the holding register is full -> only values presented on accepting edges are transmitted, none duplicated or lost.
- Assert i_Rst_n low mid-data-bit with a character queued.
  - Serial goes to 1 and Ready to 1 asynchronously; Active and Done are 0.
  - After release no further bits are sent until a new character is accepted.
